// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared kpg encoding, FSM states and prefix combine for the sequential CLA
package cla_pkg;

  typedef enum logic [1:0] {
    KPG_K = 2'b00,
    KPG_P = 2'b01,
    KPG_G = 2'b10
  } kpg_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENCODE,
    ST_LEVEL,
    ST_SUM,
    ST_DONE
  } state_t;

  // A kill or generate at the upper span decides the carry; propagate defers to the lower span.
  function automatic kpg_t kpg_combine(input kpg_t hi, input kpg_t lo);
    return (hi == KPG_P) ? lo : hi;
  endfunction

endpackage

// File: rtl/kpg_encode.sv
// rtl/kpg_encode.sv - per-bit operand to kill/propagate/generate encoder, carry-in folded into bit 0
import cla_pkg::*;

module kpg_encode #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   cin,
  output kpg_t [WIDTH-1:0]       kpg
);

  // Bit 0 never propagates: a propagating bit 0 resolves to whatever cin is.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i] && b[i]) begin
        kpg[i] = KPG_G;
      end else if (!a[i] && !b[i]) begin
        kpg[i] = KPG_K;
      end else if (i == 0) begin
        kpg[i] = cin ? KPG_G : KPG_K;
      end else begin
        kpg[i] = KPG_P;
      end
    end
  end

endmodule

// File: rtl/cla_prefix_seq.sv
// rtl/cla_prefix_seq.sv - sequential Kogge-Stone style adder, one prefix level per clock
import cla_pkg::*;

module cla_prefix_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int LEVELS = $clog2(WIDTH);

  state_t           state;
  logic [2:0]       j;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             cin_r;
  kpg_t [WIDTH-1:0] kpg_r;
  kpg_t [WIDTH-1:0] kpg_enc;
  kpg_t [WIDTH-1:0] kpg_lvl;
  logic [2*WIDTH-1:0] kpg_shifted;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_nxt;
  logic             has_p;

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  kpg_encode #(.WIDTH(WIDTH)) u_kpg_encode (
    .a   (a_r),
    .b   (b_r),
    .cin (cin_r),
    .kpg (kpg_enc)
  );

  // Level j: each position at or above 2^j looks 2^j positions down; the shift fills K below.
  always_comb begin
    kpg_shifted = kpg_r << (32'd2 << j);
    for (int i = 0; i < WIDTH; i++) begin
      kpg_lvl[i] = kpg_r[i];
      if (32'(i) >= (32'd1 << j)) begin
        kpg_lvl[i] = kpg_combine(kpg_r[i], kpg_t'(kpg_shifted[2*i +: 2]));
      end
    end
  end

  always_comb begin
    carry[0] = cin_r;
    has_p    = (kpg_r[0] == KPG_P);
    for (int i = 1; i < WIDTH; i++) begin
      carry[i] = (kpg_r[i-1] == KPG_G);
      has_p    = has_p | (kpg_r[i] == KPG_P);
    end
    sum_nxt = a_r ^ b_r ^ carry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      j         <= 3'd0;
      a_r       <= '0;
      b_r       <= '0;
      cin_r     <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        kpg_r[i] <= KPG_K;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            cin_r <= cin;
            state <= ST_ENCODE;
          end
        end
        ST_ENCODE: begin
          kpg_r <= kpg_enc;
          j     <= 3'd0;
          state <= ST_LEVEL;
        end
        ST_LEVEL: begin
          kpg_r <= kpg_lvl;
          if (j == 3'(LEVELS - 1)) begin
            j     <= 3'd0;
            state <= ST_SUM;
          end else begin
            j <= j + 3'd1;
          end
        end
        ST_SUM: begin
          sum       <= sum_nxt;
          cout      <= (kpg_r[WIDTH-1] == KPG_G);
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Every position must be resolved to K or G once all levels have run.
  assert property (@(posedge clk) disable iff (rst) (state == ST_SUM) |-> !has_p);

endmodule

// File: tb/tb_cla_prefix_seq.sv
// tb/tb_cla_prefix_seq.sv - randomized self-checking bench for cla_prefix_seq against a behavioural adder model
module tb_cla_prefix_seq;

  localparam int W  = 64;
  localparam int LV = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  cla_prefix_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Transaction-level model: busy from accept to handshake, result visible LV+2 edges after accept.
  logic         m_busy, m_valid, m_cout, m_fresh;
  logic [W-1:0] m_sum;
  logic [W:0]   m_pend;
  int           m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_sum   <= '0;
      m_cout  <= 1'b0;
      m_cnt   <= 0;
      m_fresh <= 1'b1;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_pend <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      end
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid <= 1'b0;
        m_busy  <= 1'b0;
      end
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == LV + 1) begin
        m_valid          <= 1'b1;
        {m_cout, m_sum}  <= m_pend;
        m_fresh          <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", 65'(out_valid), 65'(m_valid));
      chk("in_ready", 65'(in_ready), 65'(!m_busy));
      chk("busy", 65'(busy), 65'(m_busy));
      if (m_valid || m_fresh) begin
        chk("sum", 65'(sum), 65'(m_sum));
        chk("cout", 65'(cout), 65'(m_cout));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 65'(in_ready), 65'(1));
  endtask

  task automatic do_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc,
                       input int hold, input bit poke, output logic [W:0] res, output int lat);
    wait_ready();
    a = aa; b = bb; cin = cc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("valid_wait", 65'(out_valid), 65'(1));
    for (int k = 0; k < hold; k++) begin
      if (poke) begin
        in_valid = 1'b1;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        cin = 1'($urandom);
      end
      @(negedge clk);
    end
    res = {cout, sum};
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0]   res;
    logic [W-1:0] ra, rb;
    logic         rc;
    int           lat;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    started = 1'b1;
    chk("reset_sum", 65'(sum), 65'(0));
    chk("reset_cout", 65'(cout), 65'(0));
    chk("reset_in_ready", 65'(in_ready), 65'(1));
    chk("reset_out_valid", 65'(out_valid), 65'(0));
    rst = 1'b0;
    @(negedge clk);

    do_op({W{1'b1}}, 64'd1, 1'b0, 0, 1'b0, res, lat);
    chk("ones_plus_one", res, {1'b1, 64'h0});
    chk("latency", 65'(lat), 65'(LV + 2));

    do_op(64'd0, 64'd0, 1'b1, 1, 1'b0, res, lat);
    chk("zero_cin", res, 65'h1);

    do_op(64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 0, 1'b0, res, lat);
    chk("prop_cin1", res, {1'b1, 64'h0});
    do_op(64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 2, 1'b0, res, lat);
    chk("prop_cin0", res, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});

    // Back-pressure with in_valid pulsed in DONE and still high on the handshake edge.
    do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 5, 1'b1, res, lat);
    chk("held_result", res, {1'b0, 64'h2222_2222_2222_2211});
    chk("after_handshake_idle", 65'(in_ready), 65'(1));

    // Reset while prefix level j=3 is being computed.
    wait_ready();
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 65'(in_ready), 65'(1));
    chk("midrst_busy", 65'(busy), 65'(0));
    chk("midrst_out_valid", 65'(out_valid), 65'(0));
    chk("midrst_sum", {cout, sum}, 65'(0));
    rst = 1'b0;
    do_op(64'd3, 64'd5, 1'b0, 0, 1'b0, res, lat);
    chk("after_rst_op", res, 65'd8);

    for (int n = 0; n < 1000; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom);
      if (n % 50 == 0) ra = {W{1'b1}};
      if (n % 70 == 0) rb = ~ra;
      do_op(ra, rb, rc, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), res, lat);
      chk("rand_sum", res, {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
